// File: rtl/rle_decompressor_if.sv
// Bundles the Start/command, compressed input stream and decompressed write
// outputs of rle_decompressor into one port.
interface rle_decompressor_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int RUN_WIDTH  = 15
);
    logic                  Start;
    logic [ADDR_WIDTH:0]   Total_Words;
    logic [RUN_WIDTH:0]    In_Data;
    logic                  In_Valid;
    logic                  In_Ready;
    logic [DATA_WIDTH-1:0] Dec_Data;
    logic [ADDR_WIDTH-1:0] Dec_Addr;
    logic                  Dec_Write;
    logic                  Busy;
    logic                  Done;
    logic                  Error;

    modport slave (
        input  Start, Total_Words, In_Data, In_Valid,
        output In_Ready, Dec_Data, Dec_Addr, Dec_Write, Busy, Done, Error
    );

    modport master (
        output Start, Total_Words, In_Data, In_Valid,
        input  In_Ready, Dec_Data, Dec_Addr, Dec_Write, Busy, Done, Error
    );
endinterface

// File: rtl/rle_decompressor.sv
// Run-length decompressor: expands {bit, L} run words one bit per cycle and
// packs them LSB-first into DATA_WIDTH-bit words written at consecutive addresses.
module rle_decompressor #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int RUN_WIDTH  = 15
) (
    input  logic              Clk,
    input  logic              Rst,
    rle_decompressor_if.slave bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int RW = RUN_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, EXPAND, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         total_q, total_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RW-1:0]         remaining_q, remaining_d;
    logic                  run_bit_q, run_bit_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic [DATA_WIDTH-1:0] dec_data_q, dec_data_d;
    logic [ADDR_WIDTH-1:0] dec_addr_q, dec_addr_d;
    logic                  dec_write_q, dec_write_d;
    logic                  error_q, error_d;
    logic [RW-1:0]         rem_next;

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        run_bit_d   = run_bit_q;
        pack_d      = pack_q;
        dec_data_d  = dec_data_q;
        dec_addr_d  = dec_addr_q;
        dec_write_d = 1'b0;
        error_d     = error_q;
        rem_next    = remaining_q - RW'(1);

        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    error_d = 1'b0;
                    total_d = bus.Total_Words;
                    if (bus.Total_Words == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = FETCH;
                        word_cnt_d = '0;
                        bit_cnt_d  = '0;
                        addr_d     = '0;
                        dec_addr_d = '0;
                        pack_d     = '0;
                    end
                end
            end
            FETCH: begin
                if (bus.In_Valid) begin
                    run_bit_d   = bus.In_Data[RUN_WIDTH];
                    remaining_d = {1'b0, bus.In_Data[RUN_WIDTH-1:0]} + RW'(1);
                    state_d     = EXPAND;
                end
            end
            EXPAND: begin
                pack_d[bit_cnt_q] = run_bit_q;
                remaining_d       = rem_next;
                if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                    dec_write_d = 1'b1;
                    dec_data_d  = pack_d;
                    dec_addr_d  = addr_q;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    word_cnt_d  = word_cnt_q + CW'(1);
                    bit_cnt_d   = '0;
                    pack_d      = '0;
                    // Final word: any bits still left in the run are dropped as an overrun.
                    if (word_cnt_d == total_q) begin
                        state_d     = DONE;
                        remaining_d = '0;
                        if (rem_next != '0) error_d = 1'b1;
                    end else if (rem_next == '0) begin
                        state_d = FETCH;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (rem_next == '0) state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            total_q     <= '0;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            run_bit_q   <= 1'b0;
            pack_q      <= '0;
            dec_data_q  <= '0;
            dec_addr_q  <= '0;
            dec_write_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            run_bit_q   <= run_bit_d;
            pack_q      <= pack_d;
            dec_data_q  <= dec_data_d;
            dec_addr_q  <= dec_addr_d;
            dec_write_q <= dec_write_d;
            error_q     <= error_d;
        end
    end

    assign bus.In_Ready  = (state_q == FETCH);
    assign bus.Busy      = (state_q == FETCH) || (state_q == EXPAND);
    assign bus.Done      = (state_q == DONE);
    assign bus.Error     = error_q;
    assign bus.Dec_Data  = dec_data_q;
    assign bus.Dec_Addr  = dec_addr_q;
    assign bus.Dec_Write = dec_write_q;
endmodule

// File: tb/tb_rle_decompressor.sv
// Directed and random bench for rle_decompressor, checked against a bit-stream
// model: concatenate runs, slice into 16-bit words, flag bits left over.
module tb_rle_decompressor;
    localparam int DW = 16;
    localparam int AW = 13;
    localparam int RW = 15;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    rle_decompressor_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RUN_WIDTH(RW)) bus ();
    rle_decompressor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RUN_WIDTH(RW)) dut (
        .Clk(Clk), .Rst(Rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] wq_data[$];
    logic [31:0] wq_addr[$];
    logic        wq_done[$];
    logic        wq_err[$];

    logic [RW:0]   runs[$];
    logic [DW-1:0] exp_words[$];
    logic          exp_err;
    int            n_used;

    // Observe write strobes away from the active edge.
    always @(negedge Clk) begin
        if (bus.Dec_Write === 1'b1) begin
            wq_data.push_back(32'(bus.Dec_Data));
            wq_addr.push_back(32'(bus.Dec_Addr));
            wq_done.push_back(bus.Done);
            wq_err.push_back(bus.Error);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output: slice the concatenated run bits into words, LSB first.
    task automatic model(input int tw);
        int need = tw * DW;
        int have = 0;
        logic [DW-1:0] cur = '0;
        exp_words.delete();
        exp_err = 1'b0;
        n_used  = 0;
        foreach (runs[i]) begin
            int len;
            if (have >= need) break;
            n_used++;
            len = int'(runs[i][RW-1:0]) + 1;
            for (int k = 0; k < len; k++) begin
                if (have == need) begin exp_err = 1'b1; break; end
                cur[have % DW] = runs[i][RW];
                have++;
                if (have % DW == 0) exp_words.push_back(cur);
            end
        end
    endtask

    task automatic clear_q();
        wq_data.delete(); wq_addr.delete(); wq_done.delete(); wq_err.delete();
    endtask

    task automatic start(input int tw);
        bus.Start = 1'b1;
        bus.Total_Words = (AW+1)'(tw);
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.Total_Words = (AW+1)'($urandom);
    endtask

    task automatic feed(input logic [RW:0] w, input int stall, input string tag);
        int t = 0;
        while (bus.In_Ready !== 1'b1 && t < 2000) begin @(negedge Clk); t++; end
        chk({tag, "_fetch_timeout"}, 32'(t < 2000), 32'd1);
        for (int s = 0; s < stall; s++) begin
            @(negedge Clk);
            chk({tag, "_stall_ready"}, 32'(bus.In_Ready), 32'd1);
        end
        bus.In_Valid = 1'b1;
        bus.In_Data  = w;
        @(negedge Clk);
        bus.In_Valid = 1'b0;
        bus.In_Data  = (RW+1)'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (bus.Done !== 1'b1 && t < 5000) begin @(negedge Clk); t++; end
        chk({tag, "_done_timeout"}, 32'(t < 5000), 32'd1);
    endtask

    // Full case: start, feed the runs the model says are consumed, check writes.
    task automatic run_case(input int tw, input int max_stall, input string tag);
        model(tw);
        clear_q();
        start(tw);
        for (int i = 0; i < n_used; i++) feed(runs[i], $urandom_range(0, max_stall), tag);
        wait_done(tag);
        repeat (3) begin
            @(negedge Clk);
            chk({tag, "_no_ready_after_done"}, 32'(bus.In_Ready), 32'd0);
        end
        chk({tag, "_nwrites"}, 32'(wq_data.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < wq_data.size(); i++) begin
            chk({tag, "_data"}, wq_data[i], 32'(exp_words[i]));
            chk({tag, "_addr"}, wq_addr[i], 32'(i));
            chk({tag, "_done_at_strobe"}, 32'(wq_done[i]), 32'(i == exp_words.size() - 1));
            if (i == exp_words.size() - 1)
                chk({tag, "_err_at_strobe"}, 32'(wq_err[i]), 32'(exp_err));
        end
        chk({tag, "_error"}, 32'(bus.Error), 32'(exp_err));
        chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.In_Ready), 32'd0);
        chk({tag, "_data"}, 32'(bus.Dec_Data), 32'd0);
        chk({tag, "_addr"}, 32'(bus.Dec_Addr), 32'd0);
        chk({tag, "_write"}, 32'(bus.Dec_Write), 32'd0);
        chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.Done), 32'd0);
        chk({tag, "_error"}, 32'(bus.Error), 32'd0);
    endtask

    initial begin
        int tw, total;
        bus.Start = 1'b0; bus.Total_Words = '0; bus.In_Data = '0; bus.In_Valid = 1'b0;

        // Reset with random inputs toggling.
        Rst = 1'b1;
        repeat (2) begin
            @(negedge Clk);
            bus.Start = 1'($urandom); bus.In_Valid = 1'($urandom);
            bus.In_Data = (RW+1)'($urandom); bus.Total_Words = (AW+1)'($urandom);
        end
        @(negedge Clk);
        check_reset_outputs("reset");
        Rst = 1'b0;
        bus.Start = 1'b0; bus.In_Valid = 1'b0;
        @(negedge Clk);
        check_reset_outputs("idle");

        // Zero-word start: immediately DONE, no writes.
        clear_q();
        start(0);
        chk("tw0_done", 32'(bus.Done), 32'd1);
        chk("tw0_busy", 32'(bus.Busy), 32'd0);
        repeat (2) @(negedge Clk);
        chk("tw0_nwrites", 32'(wq_data.size()), 32'd0);

        runs.delete(); runs.push_back({1'b1, 15'd15});
        run_case(1, 0, "single");

        runs.delete(); runs.push_back({1'b0, 15'd3}); runs.push_back({1'b1, 15'd27});
        run_case(2, 0, "span");
        chk("span_w0", 32'(exp_words[0]), 32'hFFF0);
        run_case(2, 5, "stall");

        runs.delete(); runs.push_back({1'b1, 15'd19});
        run_case(1, 0, "overrun");

        // Abort mid-run, then a fresh start.
        clear_q();
        start(1);
        feed({1'b1, 15'd15}, 0, "abort");
        repeat (8) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check_reset_outputs("abort_rst");
        repeat (20) @(negedge Clk);
        chk("abort_nwrites", 32'(wq_data.size()), 32'd0);
        runs.delete(); runs.push_back({1'b0, 15'd15});
        run_case(1, 0, "restart");

        // Random runs; short runs mixed with long ones that span words.
        for (int c = 0; c < 25; c++) begin
            tw = $urandom_range(1, 4);
            runs.delete();
            total = 0;
            while (total < tw * DW + 8) begin
                logic [RW:0] w;
                w = {1'($urandom), 15'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 40 : 9))};
                runs.push_back(w);
                total += int'(w[RW-1:0]) + 1;
            end
            run_case(tw, 3, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
